line_buf_ctrl: RTL and testbench
================================

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameter IMG_W, default 320, pixels per row.
REQ-002 Parameter IMG_H, default 240, rows per frame.
REQ-003 Parameter CW, default 9, coordinate counter width; the implementation shall require 2^CW >= max(IMG_W, IMG_H).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock shared with line_buf.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 pix_valid  in  1  gray pixel present on the line_buf data input this cycle.
REQ-008 sof  in  1  start of frame, qualified by pix_valid; marks pixel (0,0).
REQ-009 shift_en  out  1  combinational line_buf shift/write enable.
REQ-010 win_valid  out  1  registered; line_buf a0..a7 plus the center form an interior 3x3 window.
REQ-011 cen_x  out  CW  registered window center column.
REQ-012 cen_y  out  CW  registered window center row.
REQ-013 busy  out  1  high in FILL or STREAM.
REQ-014 frame_done  out  1  registered one-cycle pulse after the last frame pixel.
REQ-015 err  out  1  sticky protocol error flag; see Configuration.

Function
REQ-016 The state machine SHALL have states IDLE, FILL, STREAM and DONE.
REQ-017 A pixel is accepted when pix_valid=1 and either (state=IDLE and sof=1) or state is FILL or STREAM.
REQ-018 shift_en SHALL equal pixel-accepted in the same cycle, so line_buf shifts on the same edge.
REQ-019 Internal counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL give the coordinates of the accepted pixel.
REQ-020 On an accepted pixel, col increments; at IMG_W-1 it wraps to 0 and row increments.
REQ-021 IDLE -> FILL on an accepted sof pixel; counters then denote (0,0) and the next pixel is (1,0).
REQ-022 FILL -> STREAM on acceptance of pixel (2,2).
REQ-023 FILL/STREAM -> DONE on acceptance of pixel (IMG_W-1, IMG_H-1).
REQ-024 DONE -> IDLE unconditionally after one cycle; pixels in DONE are ignored, including ones with sof=1.
REQ-025 win_valid SHALL be 1 in the cycle after accepting a pixel with col>=2 and row>=2, else 0.
REQ-026 When win_valid=1, cen_x=col-1 and cen_y=row-1 of that pixel; otherwise cen_x/cen_y hold their previous values.
REQ-027 Border centers (row/col 0 or max) SHALL never produce win_valid.
REQ-028 Exactly (IMG_W-2)*(IMG_H-2) win_valid pulses SHALL occur per complete frame.
REQ-029 frame_done SHALL be 1 in the cycle after the last pixel is accepted, i.e. while the state is DONE.
REQ-030 sof=1 with pix_valid=1 in FILL or STREAM SHALL restart: that pixel becomes (0,0), the state becomes FILL, and no win_valid is produced for it.
REQ-031 Gaps in pix_valid SHALL stall the counters and state with no output change; win_valid then stays 0.

Reset
REQ-032 rst=0 SHALL asynchronously force state IDLE, col/row/cen_x/cen_y to 0, and win_valid, frame_done and err to 0.
REQ-033 Reset mid-frame SHALL abandon the frame; the next frame starts only on a new sof.

Configuration
REQ-034 Macro LINE_BUF_CTRL_ERR_EN: when defined, err sets on sof restart in FILL/STREAM, or on pix_valid=1 in DONE, and holds until reset.
REQ-035 When LINE_BUF_CTRL_ERR_EN is undefined, err SHALL be constant 0 and no error logic is synthesized; all other behaviour is identical.

Verification
REQ-036 IMG_W=4, IMG_H=4, continuous 16-pixel frame with sof on the first pixel -> 4 win_valid pulses with centers (1,1),(2,1),(1,2),(2,2); frame_done once; busy drops.
REQ-037 Pixels without sof while in IDLE -> shift_en=0, state remains IDLE, no win_valid.
REQ-038 pix_valid deasserted for 3 cycles mid-row -> counters hold, and the center sequence is identical to the gap-free run.
REQ-039 sof reasserted at pixel (1,2) -> restart to (0,0) in FILL, err=1 with LINE_BUF_CTRL_ERR_EN defined and err=0 without; the full next frame then yields 4 windows.
REQ-040 rst=0 asserted between clock edges mid-STREAM -> all outputs 0 immediately, and state is IDLE after release.
REQ-041 Back-to-back frames with sof arriving in the DONE cycle -> sof is ignored and no windows are produced until sof is presented again in IDLE.

Source files
------------

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: pixel coordinate tracker and 3x3 window-valid sequencer for a line buffer.
// Optional sticky protocol error flag enabled by defining LINE_BUF_CTRL_ERR_EN.
module line_buf_ctrl #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic          sof,
  output logic          shift_en,
  output logic          win_valid,
  output logic [CW-1:0] cen_x,
  output logic [CW-1:0] cen_y,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  localparam logic [CW-1:0] X_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO   = CW'(2);
  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [CW-1:0] cen_x_q, cen_x_d, cen_y_q, cen_y_d;
  logic          win_valid_q, win_valid_d, frame_done_q, frame_done_d;
  logic          running, accept;
  always_comb begin
    running      = state_q == FILL || state_q == STREAM;
    accept       = pix_valid && (running || (state_q == IDLE && sof));
    col_d        = col_q;
    row_d        = row_q;
    if (accept) begin
      col_d = (sof || col_q == X_MAX) ? '0 : col_q + 1'b1;
      row_d = sof ? '0 : (col_q == X_MAX) ? row_q + 1'b1 : row_q;
    end
    // a window is complete once the accepted pixel is at least two columns and rows in
    win_valid_d  = accept && col_d >= TWO && row_d >= TWO;
    cen_x_d      = win_valid_d ? col_d - 1'b1 : cen_x_q;
    cen_y_d      = win_valid_d ? row_d - 1'b1 : cen_y_q;
    state_d      = state_q == DONE ? IDLE :
                   !accept ? state_q :
                   sof ? FILL :
                   (col_d == X_MAX && row_d == Y_MAX) ? DONE :
                   (state_q == FILL && col_d == TWO && row_d == TWO) ? STREAM : state_q;
    frame_done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cen_x_q      <= '0;
      cen_y_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cen_x_q      <= cen_x_d;
      cen_y_q      <= cen_y_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign shift_en   = accept;
  assign win_valid  = win_valid_q;
  assign cen_x      = cen_x_q;
  assign cen_y      = cen_y_q;
  assign busy       = running;
  assign frame_done = frame_done_q;
`ifdef LINE_BUF_CTRL_ERR_EN
  logic err_q, err_d;
  assign err_d = err_q || (pix_valid && ((running && sof) || state_q == DONE));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: frame-level reference model plus directed scenarios for line_buf_ctrl (4x4 image).
module tb_line_buf_ctrl;
  localparam int W = 4, H = 4, CW = 3;
`ifdef LINE_BUF_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 0, rst = 0, pix_valid = 0, sof = 0;
  logic shift_en, win_valid, busy, frame_done, err;
  logic [CW-1:0] cen_x, cen_y;
  int total = 0, bad = 0;
  int m_mode = 0, m_idx = 0, mx, my;
  bit e_win = 0, e_done = 0, e_err = 0;
  int e_cx = 0, e_cy = 0;
  int nwin = 0, ndone = 0;
  int lx[16], ly[16];
  int ecx[4] = '{1, 2, 1, 2};
  int ecy[4] = '{1, 1, 2, 2};

  line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sof(sof), .shift_en(shift_en),
    .win_valid(win_valid), .cen_x(cen_x), .cen_y(cen_y), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // mode 0 = waiting for sof, 1 = inside a frame, 2 = frame just finished
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_idx = 0; e_win = 0; e_done = 0; e_err = 0; e_cx = 0; e_cy = 0;
    end else begin
      if (ERR_EN && pix_valid && ((m_mode == 1 && sof) || m_mode == 2)) e_err = 1;
      e_win = 0;
      e_done = 0;
      if (pix_valid && (m_mode == 0 ? sof : m_mode == 1)) begin
        m_idx = (m_mode == 0 || sof) ? 0 : m_idx + 1;
        mx = m_idx % W;
        my = m_idx / W;
        if (mx >= 2 && my >= 2) begin
          e_win = 1; e_cx = mx - 1; e_cy = my - 1;
        end
        m_mode = (m_idx == W * H - 1) ? 2 : 1;
        e_done = m_mode == 2;
      end else if (m_mode == 2) m_mode = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("shift_en", shift_en, pix_valid && (m_mode == 0 ? sof : m_mode == 1));
      chk("win_valid", win_valid, e_win);
      chk("cen_x", cen_x, e_cx);
      chk("cen_y", cen_y, e_cy);
      chk("busy", busy, m_mode == 1);
      chk("frame_done", frame_done, e_done);
      chk("err", err, e_err);
      if (win_valid) begin
        if (nwin < 16) begin lx[nwin] = cen_x; ly[nwin] = cen_y; end
        nwin++;
      end
      if (frame_done) ndone++;
    end
  end

  task automatic px(input logic v, input logic s);
    @(posedge clk);
    #2;
    pix_valid = v;
    sof = s;
  endtask

  task automatic idle(input int n);
    repeat (n) px(1'b0, 1'b0);
  endtask

  task automatic clr;
    nwin = 0;
    ndone = 0;
  endtask

  task automatic frame;
    px(1'b1, 1'b1);
    repeat (W * H - 1) px(1'b1, 1'b0);
  endtask

  task automatic centers(input string nm);
    chk({nm, "_nwin"}, nwin, 4);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_cx"}, lx[i], ecx[i]);
      chk({nm, "_cy"}, ly[i], ecy[i]);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_win", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cen", {cen_x, cen_y}, 0);
    chk("rst_err", err, 0);
    rst = 1;
    idle(2);
    clr;
    frame;
    idle(4);
    centers("t1");
    chk("t1_done", ndone, 1);
    chk("t1_busy", busy, 0);
    clr;
    px(1'b1, 1'b0);
    #1 chk("t2_shift", shift_en, 0);
    repeat (4) px(1'b1, 1'b0);
    idle(2);
    chk("t2_nwin", nwin, 0);
    chk("t2_busy", busy, 0);
    clr;
    px(1'b1, 1'b1);
    repeat (5) px(1'b1, 1'b0);
    idle(3);
    repeat (10) px(1'b1, 1'b0);
    idle(4);
    centers("t3");
    chk("t3_done", ndone, 1);
    clr;
    px(1'b1, 1'b1);
    repeat (8) px(1'b1, 1'b0);
    px(1'b1, 1'b1);
    repeat (W * H - 1) px(1'b1, 1'b0);
    idle(4);
    chk("t4_err", err, ERR_EN);
    centers("t4");
    chk("t4_done", ndone, 1);
    clr;
    px(1'b1, 1'b1);
    repeat (12) px(1'b1, 1'b0);
    #1;
    chk("t5_pre_win", win_valid, 1);
    rst = 0;
    #1;
    chk("t5_win", win_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", frame_done, 0);
    chk("t5_cen", {cen_x, cen_y}, 0);
    chk("t5_err", err, 0);
    chk("t5_shift", shift_en, 0);
    pix_valid = 0;
    idle(2);
    rst = 1;
    clr;
    repeat (3) px(1'b1, 1'b0);
    idle(2);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_nwin", nwin, 0);
    clr;
    frame;
    px(1'b1, 1'b1);
    repeat (3) px(1'b1, 1'b0);
    idle(2);
    chk("t6_nwin", nwin, 4);
    chk("t6_done", ndone, 1);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, ERR_EN);
    clr;
    frame;
    idle(4);
    centers("t6b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
